// File: rtl/soc_pkg.sv
// Shared tinysoc definitions: loader FSM encodings and nibble/instruction widths.
// Imported by prog_loader.
package soc_pkg;

  typedef enum logic [1:0] {
    LD_LOAD  = 2'd0,
    LD_CHECK = 2'd1,
    LD_DONE  = 2'd2
  } ld_state_e;

  localparam int NIBBLE_W = 4;
  localparam int INSTR_W  = 16;

endpackage

// File: rtl/prog_loader.sv
// Instruction-memory loader: packs a valid-qualified nibble stream (LSB nibble first)
// into words written to imem at addresses 0..2**ADDR_WIDTH-1, then raises done.
// Ports: clk, rst (sync, high), nib_i/nib_vld_i in; wr_o/wr_addr_o/wr_data_o imem
// write port; busy_o, done_o (sticky), err_o (sticky checksum mismatch).
// Optional: define PROG_LOADER_CHECKSUM_EN for a trailing XOR checksum nibble.
module prog_loader
  import soc_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int WORD_NIBBLES = 4,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NIBBLE_W-1:0]   nib_i,
  input  logic                  nib_vld_i,
  output logic                  wr_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int CW = (WORD_NIBBLES > 1) ? $clog2(WORD_NIBBLES) : 1;

  ld_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] word;
  logic                  last_nib;
  logic                  last_word;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [NIBBLE_W-1:0]   acc_q, acc_d;
  logic                  err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    wr_d      = 1'b0;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    acc_d     = acc_q;
    err_d     = err_q;
`endif
    // Address steps at the edge that ends a write pulse, so addr_d is
    // also the address of the word currently being assembled.
    addr_d    = wr_q ? addr_q + 1'b1 : addr_q;
    word      = shift_q;
    word[NIBBLE_W*int'(cnt_q) +: NIBBLE_W] = nib_i;
    last_nib  = (cnt_q == CW'(WORD_NIBBLES - 1));
    last_word = (addr_d == '1);

    unique case (state_q)
      LD_LOAD: begin
        if (nib_vld_i) begin
          shift_d = word;
          cnt_d   = last_nib ? '0 : cnt_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          acc_d   = acc_q ^ nib_i;
`endif
          if (last_nib) begin
            wr_d      = 1'b1;
            wr_data_d = word;
            if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_d = LD_CHECK;
`else
              state_d = LD_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
`endif
            end
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      LD_CHECK: begin
        if (nib_vld_i) begin
          state_d = LD_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = (nib_i != acc_q);
        end
      end
`endif
      LD_DONE: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LD_LOAD;
      cnt_q     <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wr_data_q <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      acc_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      acc_q     <= acc_d;
      err_q     <= err_d;
`endif
    end
  end

  assign wr_o      = wr_q;
  assign wr_addr_o = addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign err_o     = err_q;
`else
  assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
// Checksum scenarios run only when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  nib_i = '0;
  logic        nib_vld_i = 1'b0;
  logic        wr_o;
  logic [3:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  logic [3:0]  log_addr [256];
  logic [15:0] log_data [256];
  int          wr_cnt = 0;
  int          dbl = 0;
  logic        wr_prev = 1'b0;

  logic [15:0] exp1 [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
  logic [15:0] exp3 [4] = '{16'h8765, 16'hCBA9, 16'h0FED, 16'h4321};

  prog_loader #(
    .ADDR_WIDTH(4),
    .WORD_NIBBLES(4),
    .DATA_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .nib_i(nib_i),
    .nib_vld_i(nib_vld_i),
    .wr_o(wr_o),
    .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_o) begin
      if (wr_prev) dbl++;
      if (wr_cnt < 256) begin
        log_addr[wr_cnt] = wr_addr_o;
        log_data[wr_cnt] = wr_data_o;
      end
      wr_cnt++;
    end
    wr_prev = wr_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] n);
    @(negedge clk);
    nib_i = n;
    nib_vld_i = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    nib_vld_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    nib_vld_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // 64 nibbles (base + step*i) mod 16, with 'gaps' idle cycles between them
  task automatic load(input int base, input int step, input int gaps);
    for (int i = 0; i < 64; i++) begin
      send(4'((base + step * i) % 16));
      if (i < 63)
        repeat (gaps) idle();
    end
  endtask

  task automatic check_log(input string tag, input int b, input int useexp3);
    chk({tag, "_cnt"}, wr_cnt - b, 16);
    for (int k = 0; k < 16; k++) begin
      chk({tag, "_addr"}, 32'(log_addr[b + k]), k);
      chk({tag, "_data"}, 32'(log_data[b + k]),
          useexp3 != 0 ? 32'(exp3[k % 4]) : 32'(exp1[k % 4]));
    end
  endtask

  initial begin
    int b;
    int c;

    // reset state
    do_reset();
    chk("rst_wr", 32'(wr_o), 0);
    chk("rst_addr", 32'(wr_addr_o), 0);
    chk("rst_data", 32'(wr_data_o), 0);
    chk("rst_busy", 32'(busy_o), 1);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);

    // 1: continuous stream
    b = wr_cnt;
    load(0, 1, 0);
    chk("t1_done_early", 32'(done_o), 0);
    chk("t1_busy_early", 32'(busy_o), 1);
    idle();
    chk("t1_done", 32'(done_o), 1);
    chk("t1_busy", 32'(busy_o), 0);
    chk("t1_lastwr", 32'(wr_o), 1);
    chk("t1_lastaddr", 32'(wr_addr_o), 15);
    idle();
    chk("t1_wr_off", 32'(wr_o), 0);
    chk("t1_addr_wrap", 32'(wr_addr_o), 0);
    chk("t1_err", 32'(err_o), 0);
    idle();
    check_log("t1", b, 0);

    // 2: valid pattern 1,0,0
    do_reset();
    chk("t2_rst_done", 32'(done_o), 0);
    b = wr_cnt;
    load(0, 1, 2);
    chk("t2_done_early", 32'(done_o), 0);
    idle();
    chk("t2_done", 32'(done_o), 1);
    repeat (2) idle();
    check_log("t2", b, 0);
    chk("t2_single_pulse", dbl, 0);

    // 3: reset after 22 nibbles, then a fresh full load
    do_reset();
    b = wr_cnt;
    for (int i = 0; i < 22; i++) send(4'(i % 16));
    idle();
    chk("t3_part_cnt", wr_cnt - b, 5);
    chk("t3_part_done", 32'(done_o), 0);
    do_reset();
    chk("t3_rst_addr", 32'(wr_addr_o), 0);
    chk("t3_rst_done", 32'(done_o), 0);
    b = wr_cnt;
    load(5, 1, 0);
    chk("t3_done_early", 32'(done_o), 0);
    idle();
    chk("t3_done", 32'(done_o), 1);
    repeat (2) idle();
    check_log("t3", b, 1);

    // 4: nibbles after done are ignored
    c = wr_cnt;
    for (int i = 0; i < 8; i++) send(4'(i + 3));
    idle();
    chk("t4_wr", 32'(wr_o), 0);
    idle();
    chk("t4_cnt", wr_cnt - c, 0);
    chk("t4_done", 32'(done_o), 1);
    chk("t4_busy", 32'(busy_o), 0);
    chk("t4_addr", 32'(wr_addr_o), 0);
    chk("t4_data", 32'(wr_data_o), 32'h4321);
    chk("t4_err", 32'(err_o), 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // 5: all-A data, matching check nibble 0
    do_reset();
    b = wr_cnt;
    load(10, 0, 0);
    idle();
    chk("t5_check_busy", 32'(busy_o), 1);
    chk("t5_check_done", 32'(done_o), 0);
    idle();
    chk("t5_check_wr", 32'(wr_o), 0);
    chk("t5_cnt", wr_cnt - b, 16);
    chk("t5_data", 32'(wr_data_o), 32'hAAAA);
    send(4'h0);
    idle();
    chk("t5_done", 32'(done_o), 1);
    chk("t5_busy", 32'(busy_o), 0);
    chk("t5_err", 32'(err_o), 0);

    // 6: same data, wrong check nibble 1
    do_reset();
    load(10, 0, 0);
    repeat (2) idle();
    chk("t6_check_done", 32'(done_o), 0);
    send(4'h1);
    idle();
    chk("t6_done", 32'(done_o), 1);
    chk("t6_err", 32'(err_o), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
